keypad_entry: RTL and testbench
===============================

# keypad_entry

Front-end stage for the door-lock password checker. Debounces a raw keypad strobe and the enter/mode buttons, assembles up to five decimal digits into a 17-bit binary value, and presents the password, the new password and the mode level to the checker. Each completed entry produces one clean enter pulse. It feeds the checker's password, change-password, reset-mode and enter inputs directly.

## Interface
- DEBOUNCE_CYCLES, 20000: cycles a raw input must stay stable before it is accepted.
- PULSE_CYCLES, 4: width of the enter pulse in cycles; at least 1.
- TIMEOUT_CYCLES, 50_000_000: idle cycles before a partial entry is discarded.
- MAX_DIGITS, 5: digits accepted per field; 99999 fits in 17 bits.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- key_press_raw  in  1  raw keypad strobe; high while a key is held.
- key_code_raw  in  4  raw key code: 0-9 are digits, 10 is clear, 11 is backspace, 12-15 are ignored.
- enter_raw  in  1  raw enter button.
- mode_raw  in  1  raw mode switch; 1 selects change-password mode.
- in_password  out  17  entered password, binary.
- change_password  out  17  entered new password, binary.
- rs_mode  out  1  mode level presented with the entry.
- enter_pulse  out  1  enter strobe to the checker.
- digit_count  out  3  digits in the field currently being edited, for the display.
- busy  out  1  high while an entry is in progress or a pulse is being driven.

## Operation
- Every raw input passes through a 2-flop synchronizer and then a debouncer. A level is accepted only after DEBOUNCE_CYCLES consecutive equal samples. Each debouncer emits a one-cycle rise pulse when its accepted level goes 0 to 1.
- key_code_raw is synchronized and sampled in the same cycle as the key_press rise pulse.
- The mode level is sampled in IDLE on the first accepted event.
- Accumulators: pw_acc and new_acc, each 17 bits, each paired with its own digit count.
- Digit d goes into the active field: acc = acc*10 + d, count + 1. When count == MAX_DIGITS the digit is ignored.
- Clear sets the active field's acc and count to 0.
- Backspace sets acc = acc/10, count - 1. When count == 0 it has no effect.
- States:
  - IDLE: a key or enter event goes to PW. A digit key in IDLE is applied in the same cycle. An enter event in IDLE is handled as below with an empty field.
  - PW: on enter, mode 0 goes to LOAD; mode 1 goes to NEW.
  - NEW: key events edit new_acc; enter goes to LOAD.
  - LOAD, 1 cycle: in_password = pw_acc. change_password = new_acc when mode is 1, otherwise it keeps its value. rs_mode = latched mode. Both accumulators and counts clear. Next state is PULSE.
  - PULSE: enter_pulse = 1 for PULSE_CYCLES cycles, then IDLE.
- Key and enter events that arrive during LOAD or PULSE are dropped.
- A mode change after entry has started is ignored until IDLE.
- Inactivity timer: runs in PW and NEW and resets on every accepted event. At TIMEOUT_CYCLES both fields clear and the state returns to IDLE. No pulse is produced and the outputs keep their values.
- A key event and an enter event in the same cycle: the key is applied first, then the enter.

## Timing
- Reset values: in_password 0, change_password 0, rs_mode 0, enter_pulse 0, digit_count 0, busy 0. State is IDLE and all counters are 0.
- Reset asserted mid-entry or mid-pulse forces the reset values immediately, asynchronously. enter_pulse drops with no completion.
- Raw edge to accepted event: 2 synchronizer cycles + DEBOUNCE_CYCLES + 1.
- Accepted enter to outputs valid: 1 cycle, in LOAD.
- enter_pulse rises the cycle after LOAD. in_password, change_password and rs_mode are therefore stable for at least 1 cycle before the rising edge, and are held until the next LOAD.
- busy is high in PW, NEW, LOAD and PULSE.
- digit_count reflects the active field in the same cycle as the update.

## Structure
- Shared package keypad_pkg holds:
  - the key code constants KEY_CLEAR = 10 and KEY_BKSP = 11,
  - the state enum IDLE, PW, NEW, LOAD, PULSE,
  - the 17-bit password width constant.
- One sub-module, debouncer, parameterized by DEBOUNCE_CYCLES. It contains the synchronizer, the stable counter and the rise-pulse logic. It is instantiated three times: key_press, enter and mode. key_code uses a plain synchronizer.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, PULSE_CYCLES=2, TIMEOUT_CYCLES=200.
- Mode 0, keys 4,5,6,7,5, then enter -> in_password=45675, rs_mode=0, enter_pulse high 2 cycles starting one cycle after LOAD.
- Mode 1, keys 4,5,6,7,5, enter, keys 7,8,9,5,4, enter -> in_password=45675, change_password=78954, rs_mode=1, one 2-cycle pulse.
- Keys 1,2,3,4,5,6 -> value 12345, digit_count 5. Then backspace -> 1234, count 4. Then clear -> 0, count 0.
- Key strobe that bounces with 1-3 cycle glitches before settling -> exactly one digit accepted. A single 2-cycle glitch alone -> nothing accepted.
- Keys 9,9, then 200 idle cycles -> back in IDLE, busy=0, no pulse, previous outputs retained.
- rst_n asserted during PULSE -> enter_pulse, outputs and busy go to 0 at once. After release, a fresh entry of 1 followed by enter gives in_password=1.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad entry front end.
// Key codes, FSM states and the digit field editor.
package keypad_pkg;

  localparam int PW_W = 17;

  localparam logic [3:0] KEY_CLEAR = 4'd10;
  localparam logic [3:0] KEY_BKSP  = 4'd11;

  typedef enum logic [2:0] {
    IDLE,
    PW,
    NEW,
    LOAD,
    PULSE
  } state_t;

  typedef struct packed {
    logic [PW_W-1:0] acc;
    logic [2:0]      cnt;
  } field_t;

  // Applies one key code to a digit field; codes 12-15 fall through.
  function automatic field_t edit_field(
    input field_t     f,
    input logic [3:0] code,
    input logic [2:0] max_d
  );
    field_t r;
    r = f;
    unique case (1'b1)
      (code <= 4'd9): begin
        if (f.cnt < max_d) begin
          r.acc = f.acc * PW_W'(10) + PW_W'(code);
          r.cnt = f.cnt + 3'd1;
        end
      end
      (code == KEY_CLEAR): r = '0;
      (code == KEY_BKSP): begin
        if (f.cnt != 3'd0) begin
          r.acc = f.acc / PW_W'(10);
          r.cnt = f.cnt - 3'd1;
        end
      end
      default: r = f;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/keypad_entry_debouncer.sv
// Two-flop synchronizer plus stable-count debouncer.
// Emits a one-cycle rise pulse on an accepted 0->1 change.
module debouncer #(
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;
  logic          hit;

  assign hit = (s2 != level) &&
               (cnt == CW'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      s1   <= raw;
      s2   <= s1;
      rise <= hit & s2;
      if (s2 == level) begin
        cnt <= '0;
      end else if (hit) begin
        cnt   <= '0;
        level <= s2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/keypad_entry.sv
// Keypad front end: debounces inputs, assembles decimal fields
// and hands password, new password and mode to the checker.
module keypad_entry
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int PULSE_CYCLES    = 4,
  parameter int TIMEOUT_CYCLES  = 50_000_000,
  parameter int MAX_DIGITS      = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            key_press_raw,
  input  logic [3:0]      key_code_raw,
  input  logic            enter_raw,
  input  logic            mode_raw,
  output logic [PW_W-1:0] in_password,
  output logic [PW_W-1:0] change_password,
  output logic            rs_mode,
  output logic            enter_pulse,
  output logic [2:0]      digit_count,
  output logic            busy
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int PCW = $clog2(PULSE_CYCLES + 1);
  localparam logic [2:0] MAXD = 3'(MAX_DIGITS);

  logic key_rise;
  logic enter_rise;
  logic mode_lvl;
  logic key_lvl;
  logic enter_lvl;
  logic [3:0] kc1;
  logic [3:0] kc2;

  state_t          state, state_n;
  field_t          pw, pw_n;
  field_t          nw, nw_n;
  logic            mode_q, mode_n;
  logic [TW-1:0]   timer, timer_n;
  logic [PCW-1:0]  pcnt, pcnt_n;
  logic [PW_W-1:0] in_pw_n;
  logic [PW_W-1:0] chg_n;
  logic            rs_n;

  debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (key_press_raw),
    .level (key_lvl),
    .rise  (key_rise)
  );

  debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (enter_raw),
    .level (enter_lvl),
    .rise  (enter_rise)
  );

  debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (mode_raw),
    .level (mode_lvl),
    .rise  ()
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kc1 <= '0;
      kc2 <= '0;
    end else begin
      kc1 <= key_code_raw;
      kc2 <= kc1;
    end
  end

  assign busy        = (state != IDLE);
  assign digit_count = (state == NEW) ? nw.cnt : pw.cnt;

  always_comb begin
    state_n = state;
    pw_n    = pw;
    nw_n    = nw;
    mode_n  = mode_q;
    timer_n = timer;
    pcnt_n  = pcnt;
    in_pw_n = in_password;
    chg_n   = change_password;
    rs_n    = rs_mode;
    unique case (state)
      IDLE: begin
        timer_n = '0;
        if (key_rise || enter_rise) begin
          mode_n  = mode_lvl;
          state_n = PW;
          if (key_rise) pw_n = edit_field(pw, kc2, MAXD);
          if (enter_rise) state_n = mode_lvl ? NEW : LOAD;
        end
      end
      PW, NEW: begin
        if (key_rise) begin
          if (state == NEW) nw_n = edit_field(nw, kc2, MAXD);
          else              pw_n = edit_field(pw, kc2, MAXD);
        end
        if (enter_rise) begin
          state_n = (state == NEW || !mode_q) ? LOAD : NEW;
        end
        if (key_rise || enter_rise) begin
          timer_n = '0;
        end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
          pw_n    = '0;
          nw_n    = '0;
          timer_n = '0;
          state_n = IDLE;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      LOAD: begin
        pw_n    = '0;
        nw_n    = '0;
        pcnt_n  = '0;
        state_n = PULSE;
      end
      PULSE: begin
        if (pcnt == PCW'(PULSE_CYCLES - 1)) state_n = IDLE;
        else                                pcnt_n = pcnt + 1'b1;
      end
      default: state_n = IDLE;
    endcase
    // Outputs settle on entry to LOAD so they lead the pulse by a cycle.
    if (state != LOAD && state_n == LOAD) begin
      in_pw_n = pw_n.acc;
      if (mode_n) chg_n = nw_n.acc;
      rs_n = mode_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      pw              <= '0;
      nw              <= '0;
      mode_q          <= 1'b0;
      timer           <= '0;
      pcnt            <= '0;
      in_password     <= '0;
      change_password <= '0;
      rs_mode         <= 1'b0;
      enter_pulse     <= 1'b0;
    end else begin
      state           <= state_n;
      pw              <= pw_n;
      nw              <= nw_n;
      mode_q          <= mode_n;
      timer           <= timer_n;
      pcnt            <= pcnt_n;
      in_password     <= in_pw_n;
      change_password <= chg_n;
      rs_mode         <= rs_n;
      enter_pulse     <= (state_n == PULSE);
    end
  end

endmodule

// File: tb/tb_keypad_entry.sv
// Directed bench for keypad_entry with short debounce,
// pulse and timeout settings.
module tb_keypad_entry;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        key_press_raw = 1'b0;
  logic [3:0]  key_code_raw = 4'd0;
  logic        enter_raw = 1'b0;
  logic        mode_raw = 1'b0;
  logic [16:0] in_password;
  logic [16:0] change_password;
  logic        rs_mode;
  logic        enter_pulse;
  logic [2:0]  digit_count;
  logic        busy;

  int nvec = 0;
  int nerr = 0;

  int          rises = 0;
  int          run = 0;
  int          last_run = 0;
  logic        pulse_prev = 1'b0;
  logic [16:0] last_in = '0;
  logic [16:0] pre_in = '0;

  always #5 clk = ~clk;

  keypad_entry #(
    .DEBOUNCE_CYCLES (4),
    .PULSE_CYCLES    (2),
    .TIMEOUT_CYCLES  (200),
    .MAX_DIGITS      (5)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .key_press_raw   (key_press_raw),
    .key_code_raw    (key_code_raw),
    .enter_raw       (enter_raw),
    .mode_raw        (mode_raw),
    .in_password     (in_password),
    .change_password (change_password),
    .rs_mode         (rs_mode),
    .enter_pulse     (enter_pulse),
    .digit_count     (digit_count),
    .busy            (busy)
  );

  always @(negedge clk) begin
    if (enter_pulse && !pulse_prev) begin
      rises  = rises + 1;
      pre_in = last_in;
    end
    if (enter_pulse) begin
      run = run + 1;
    end else if (pulse_prev) begin
      last_run = run;
      run = 0;
    end
    pulse_prev = enter_pulse;
    last_in    = in_password;
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press_key(input logic [3:0] c);
    key_code_raw  = c;
    key_press_raw = 1'b1;
    cycles(10);
    key_press_raw = 1'b0;
    cycles(10);
  endtask

  task automatic press_enter();
    enter_raw = 1'b1;
    cycles(10);
    enter_raw = 1'b0;
    cycles(10);
  endtask

  task automatic hold_key(input logic v, input int n);
    key_press_raw = v;
    cycles(n);
  endtask

  task automatic test_reset();
    nvec += 6;
    if (in_password !== 17'd0) begin
      nerr++; $display("FAIL rst_in got %0d want 0", in_password);
    end
    if (change_password !== 17'd0) begin
      nerr++; $display("FAIL rst_chg got %0d want 0", change_password);
    end
    if (rs_mode !== 1'b0) begin
      nerr++; $display("FAIL rst_rs got %b want 0", rs_mode);
    end
    if (enter_pulse !== 1'b0) begin
      nerr++; $display("FAIL rst_pulse got %b want 0", enter_pulse);
    end
    if (digit_count !== 3'd0) begin
      nerr++; $display("FAIL rst_dc got %0d want 0", digit_count);
    end
    if (busy !== 1'b0) begin
      nerr++; $display("FAIL rst_busy got %b want 0", busy);
    end
    rst_n = 1'b1;
    cycles(5);
    nvec++;
    if (busy !== 1'b0 || digit_count !== 3'd0) begin
      nerr++;
      $display("FAIL rst_release busy=%b dc=%0d want 0/0",
               busy, digit_count);
    end
  endtask

  task automatic test_mode0();
    int r0;
    r0 = rises;
    press_key(4'd4); press_key(4'd5); press_key(4'd6);
    press_key(4'd7); press_key(4'd5);
    nvec += 2;
    if (digit_count !== 3'd5) begin
      nerr++; $display("FAIL m0_dc got %0d want 5", digit_count);
    end
    if (busy !== 1'b1) begin
      nerr++; $display("FAIL m0_busy got %b want 1", busy);
    end
    press_enter();
    nvec += 6;
    if (in_password !== 17'd45675) begin
      nerr++; $display("FAIL m0_in got %0d want 45675", in_password);
    end
    if (rs_mode !== 1'b0) begin
      nerr++; $display("FAIL m0_rs got %b want 0", rs_mode);
    end
    if (rises - r0 !== 1) begin
      nerr++; $display("FAIL m0_npulse got %0d want 1", rises - r0);
    end
    if (last_run !== 2) begin
      nerr++; $display("FAIL m0_width got %0d want 2", last_run);
    end
    if (pre_in !== 17'd45675) begin
      nerr++; $display("FAIL m0_setup got %0d want 45675", pre_in);
    end
    if (busy !== 1'b0 || digit_count !== 3'd0) begin
      nerr++;
      $display("FAIL m0_idle busy=%b dc=%0d want 0/0",
               busy, digit_count);
    end
  endtask

  task automatic test_mode1();
    int r0;
    mode_raw = 1'b1;
    cycles(15);
    r0 = rises;
    press_key(4'd4); press_key(4'd5); press_key(4'd6);
    press_key(4'd7); press_key(4'd5);
    press_enter();
    nvec += 2;
    if (digit_count !== 3'd0) begin
      nerr++; $display("FAIL m1_newdc got %0d want 0", digit_count);
    end
    if (rises !== r0) begin
      nerr++; $display("FAIL m1_early got %0d want %0d", rises, r0);
    end
    press_key(4'd7); press_key(4'd8); press_key(4'd9);
    press_key(4'd5); press_key(4'd4);
    nvec++;
    if (digit_count !== 3'd5) begin
      nerr++; $display("FAIL m1_dc got %0d want 5", digit_count);
    end
    press_enter();
    nvec += 5;
    if (in_password !== 17'd45675) begin
      nerr++; $display("FAIL m1_in got %0d want 45675", in_password);
    end
    if (change_password !== 17'd78954) begin
      nerr++;
      $display("FAIL m1_chg got %0d want 78954", change_password);
    end
    if (rs_mode !== 1'b1) begin
      nerr++; $display("FAIL m1_rs got %b want 1", rs_mode);
    end
    if (rises - r0 !== 1) begin
      nerr++; $display("FAIL m1_npulse got %0d want 1", rises - r0);
    end
    if (last_run !== 2) begin
      nerr++; $display("FAIL m1_width got %0d want 2", last_run);
    end
    mode_raw = 1'b0;
    cycles(15);
  endtask

  task automatic test_edit();
    for (int d = 1; d <= 6; d++) press_key(4'(d));
    nvec++;
    if (digit_count !== 3'd5) begin
      nerr++; $display("FAIL ed_dc6 got %0d want 5", digit_count);
    end
    press_key(4'd11);
    nvec++;
    if (digit_count !== 3'd4) begin
      nerr++; $display("FAIL ed_bk got %0d want 4", digit_count);
    end
    press_key(4'd10);
    nvec++;
    if (digit_count !== 3'd0) begin
      nerr++; $display("FAIL ed_clr got %0d want 0", digit_count);
    end
    press_key(4'd11);
    nvec++;
    if (digit_count !== 3'd0) begin
      nerr++; $display("FAIL ed_bk0 got %0d want 0", digit_count);
    end
    for (int d = 1; d <= 6; d++) press_key(4'(d));
    press_enter();
    nvec++;
    if (in_password !== 17'd12345) begin
      nerr++; $display("FAIL ed_val got %0d want 12345", in_password);
    end
    for (int d = 1; d <= 5; d++) press_key(4'(d));
    press_key(4'd11);
    press_key(4'd14);
    press_enter();
    nvec++;
    if (in_password !== 17'd1234) begin
      nerr++; $display("FAIL ed_bkval got %0d want 1234", in_password);
    end
    press_key(4'd7); press_key(4'd8); press_key(4'd10);
    press_enter();
    nvec++;
    if (in_password !== 17'd0) begin
      nerr++; $display("FAIL ed_clrval got %0d want 0", in_password);
    end
  endtask

  task automatic test_bounce();
    int r0;
    r0 = rises;
    key_code_raw = 4'd3;
    hold_key(1'b1, 1); hold_key(1'b0, 1);
    hold_key(1'b1, 2); hold_key(1'b0, 2);
    hold_key(1'b1, 3); hold_key(1'b0, 1);
    hold_key(1'b1, 12);
    hold_key(1'b0, 1); hold_key(1'b1, 3);
    hold_key(1'b0, 2); hold_key(1'b1, 1);
    hold_key(1'b0, 12);
    nvec++;
    if (digit_count !== 3'd1) begin
      nerr++; $display("FAIL bn_one got %0d want 1", digit_count);
    end
    hold_key(1'b1, 2); hold_key(1'b0, 12);
    nvec++;
    if (digit_count !== 3'd1) begin
      nerr++; $display("FAIL bn_glitch got %0d want 1", digit_count);
    end
    press_enter();
    nvec += 2;
    if (in_password !== 17'd3) begin
      nerr++; $display("FAIL bn_val got %0d want 3", in_password);
    end
    if (rises - r0 !== 1) begin
      nerr++; $display("FAIL bn_npulse got %0d want 1", rises - r0);
    end
  endtask

  task automatic test_timeout();
    int r0;
    r0 = rises;
    press_key(4'd9); press_key(4'd9);
    nvec++;
    if (busy !== 1'b1 || digit_count !== 3'd2) begin
      nerr++;
      $display("FAIL to_entry busy=%b dc=%0d want 1/2",
               busy, digit_count);
    end
    cycles(150);
    nvec++;
    if (busy !== 1'b1) begin
      nerr++; $display("FAIL to_early got busy=%b want 1", busy);
    end
    cycles(60);
    nvec += 4;
    if (busy !== 1'b0) begin
      nerr++; $display("FAIL to_busy got %b want 0", busy);
    end
    if (digit_count !== 3'd0) begin
      nerr++; $display("FAIL to_dc got %0d want 0", digit_count);
    end
    if (rises !== r0) begin
      nerr++; $display("FAIL to_pulse got %0d want %0d", rises, r0);
    end
    if (in_password !== 17'd3) begin
      nerr++; $display("FAIL to_keep got %0d want 3", in_password);
    end
    press_key(4'd12);
    press_enter();
    nvec++;
    if (in_password !== 17'd0) begin
      nerr++; $display("FAIL to_fresh got %0d want 0", in_password);
    end
  endtask

  task automatic test_reset_pulse();
    int r0;
    bit seen;
    seen = 1'b0;
    press_key(4'd7);
    enter_raw = 1'b1;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (enter_pulse) seen = 1'b1;
    end
    nvec++;
    if (!seen) begin
      nerr++; $display("FAIL rp_wait got no pulse want pulse");
    end
    nvec++;
    if (in_password !== 17'd7) begin
      nerr++; $display("FAIL rp_pre got %0d want 7", in_password);
    end
    #2 rst_n = 1'b0;
    #1;
    nvec += 4;
    if (enter_pulse !== 1'b0) begin
      nerr++; $display("FAIL rp_pulse got %b want 0", enter_pulse);
    end
    if (in_password !== 17'd0) begin
      nerr++; $display("FAIL rp_in got %0d want 0", in_password);
    end
    if (change_password !== 17'd0 || rs_mode !== 1'b0) begin
      nerr++;
      $display("FAIL rp_chg got %0d/%b want 0/0",
               change_password, rs_mode);
    end
    if (busy !== 1'b0) begin
      nerr++; $display("FAIL rp_busy got %b want 0", busy);
    end
    enter_raw = 1'b0;
    cycles(3);
    rst_n = 1'b1;
    cycles(3);
    r0 = rises;
    press_key(4'd1);
    press_enter();
    nvec += 2;
    if (in_password !== 17'd1) begin
      nerr++; $display("FAIL rp_fresh got %0d want 1", in_password);
    end
    if (rises - r0 !== 1) begin
      nerr++; $display("FAIL rp_npulse got %0d want 1", rises - r0);
    end
  endtask

  initial begin
    cycles(3);
    test_reset();
    test_mode0();
    test_mode1();
    test_edit();
    test_bounce();
    test_timeout();
    test_reset_pulse();
    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
